// File: rtl/ex_mac_accum.sv
// ex_mac_accum
//   Sums a run of `len` unsigned samples from the upstream multiply-add
//   pipeline into an ACC_W-bit accumulator. It then presents the total, the
//   sample count and a sticky overflow flag on a held output handshake. Only
//   one run is in flight at a time. Upstream is back-pressured (in_ready=0)
//   outside the accumulate phase.
//
//   Build option: define EX_ACC_SAT_EN to saturate the accumulator at
//   2^ACC_W-1. When it is not defined, the accumulator wraps modulo 2^ACC_W.
//
//   Ports
//     clk        : clock, rising edge
//     clear_n    : asynchronous active-low reset
//     start      : run request, sampled only in IDLE
//     len        : run length, latched on accepted start
//     in_valid   : upstream sample valid
//     in_data    : upstream sample (unsigned)
//     in_ready   : sample accepted this cycle when in_valid is also high
//     out_valid  : result available (held until taken)
//     out_ready  : downstream takes the result
//     out_data   : accumulated total
//     out_count  : samples accepted in this run
//     out_ovf    : sticky; the run total exceeded 2^ACC_W-1
//     busy       : state is not IDLE
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for start; in_ready=0, out_valid=0
//   ACCUM  | accepting samples until len have been summed
//   DONE   | result held on out_* until out_valid & out_ready

module ex_mac_accum #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 10,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [LEN_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;
    logic [LEN_W-1:0] cnt_inc;
    logic             accept;
    logic             start_ok;

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    assign out_data  = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

    assign accept   = in_ready & in_valid;
    assign start_ok = (state == S_IDLE) & start;
    assign cnt_inc  = cnt + LEN_W'(1);

    // The extra top bit of the sum is the overflow indication.
    assign sum = {1'b0, acc} + (ACC_W+1)'(in_data);

`ifdef EX_ACC_SAT_EN
    assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept && (cnt_inc == len_q)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            len_q <= '0;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (start_ok) begin
            len_q <= len;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_inc;
            if (sum[ACC_W]) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_mac_accum.sv
module tb_ex_mac_accum;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 10;
    localparam int LEN_W  = 4;
    localparam int MAXV   = (1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              clear_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [LEN_W-1:0]  out_count;
    logic              out_ovf;
    logic              busy;

    typedef struct {
        int data;
        int count;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   samp[16];
    int   errors = 0;
    int   checks = 0;

    ex_mac_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: sums samp[0..n-1] the way the accumulator should.
    task automatic model_push(input int n);
        exp_t e;
        int   a = 0;
        int   o = 0;
        for (int i = 0; i < n; i++) begin
            int s = a + samp[i];
            if (s > MAXV) o = 1;
`ifdef EX_ACC_SAT_EN
            a = (s > MAXV) ? MAXV : s;
`else
            a = s % (MAXV + 1);
`endif
        end
        e.data  = a;
        e.count = n;
        e.ovf   = o;
        sb.push_back(e);
    endtask

    task automatic start_run(input int n);
        len   = LEN_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (n > 0) chk("accum_in_ready", int'(in_ready), 1);
        else       chk("zero_len_out_valid", int'(out_valid), 1);
    endtask

    task automatic feed(input int n, input int gaps);
        int i   = 0;
        int cyc = 0;
        logic acc_ok;
        while (i < n && cyc < 200) begin
            if (gaps != 0 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = DATA_W'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = DATA_W'(samp[i]);
            end
            acc_ok = in_valid & in_ready;
            tick();
            if (acc_ok) i++;
            cyc++;
        end
        in_valid = 1'b0;
        if (i < n) chk("feed_timeout", i, n);
        else       chk("done_latency", int'(out_valid), 1);
    endtask

    task automatic collect(input int hold, input int poke_start);
        exp_t e;
        int   cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("out_count", int'(out_count), e.count);
        chk("out_ovf", int'(out_ovf), e.ovf);
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (poke_start != 0 && k == 2) begin
                start = 1'b1;
                len   = LEN_W'(3);
            end
            tick();
            start = 1'b0;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_data", int'(out_data), e.data);
            chk("hold_count", int'(out_count), e.count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_busy", int'(busy), 0);
        chk("idle_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_n   = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_busy", int'(busy), 0);
        tick();
        clear_n = 1'b1;
        tick();

        // Basic run
        samp[0] = 10; samp[1] = 20; samp[2] = 30;
        model_push(3);
        start_run(3);
        feed(3, 0);
        collect(0, 0);

        // Overflow run, followed directly by a back-to-back short run
        for (int i = 0; i < 15; i++) samp[i] = 255;
        model_push(15);
        start_run(15);
        feed(15, 0);
        collect(0, 0);
        samp[0] = 1; samp[1] = 2;
        model_push(2);
        start_run(2);
        feed(2, 0);
        collect(0, 0);

        // Gapped input, then output backpressure with a stray start in DONE
        for (int i = 0; i < 5; i++) samp[i] = i + 1;
        model_push(5);
        start_run(5);
        feed(5, 1);
        collect(10, 1);
        tick();
        chk("stray_start_busy", int'(busy), 0);

        // Zero length; offered samples must not be consumed
        model_push(0);
        start_run(0);
        chk("zero_in_ready", int'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = 8'd99;
        collect(0, 0);
        in_valid = 1'b0;

        // Reset mid-run
        tick();
        start_run(4);
        in_valid = 1'b1;
        in_data  = 8'd50;
        tick();
        in_data  = 8'd60;
        tick();
        in_valid = 1'b0;
        chk("pre_reset_data", int'(out_data), 110);
        #2;
        clear_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_count", int'(out_count), 0);
        chk("arst_out_ovf", int'(out_ovf), 0);
        tick();
        clear_n = 1'b1;
        tick();
        chk("post_reset_busy", int'(busy), 0);
        samp[0] = 7; samp[1] = 8;
        model_push(2);
        start_run(2);
        feed(2, 0);
        collect(0, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mac_accum.md
# ex_mac_accum

Result accumulator placed directly downstream of the multiply-add pipeline that produces the 8-bit `S = A*B + C` stream. It consumes a run of `len` pipeline results over a valid/ready handshake and sums them into an `ACC_W`-bit accumulator. It presents the total, the sample count and an overflow flag on a held output handshake. One run is in flight at a time, and the upstream stream is back-pressured outside the accumulate phase.

## Interface
- `DATA_W`, default 8: input sample width; matches the pipeline result width.
- `ACC_W`, default 10: accumulator and result width.
- `LEN_W`, default 4: width of the run-length and count fields.

- `clk`, in, 1: single clock, rising edge.
- `clear_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle run request; sampled only in IDLE.
- `len`, in, LEN_W: number of samples in the run; latched on accepted `start`.
- `in_valid`, in, 1: upstream sample valid.
- `in_data`, in, DATA_W: upstream sample (unsigned).
- `in_ready`, out, 1: block accepts a sample this cycle.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: downstream takes the result.
- `out_data`, out, ACC_W: accumulated total.
- `out_count`, out, LEN_W: samples accepted in this run.
- `out_ovf`, out, 1: sticky flag; the run exceeded `2^ACC_W-1`.
- `busy`, out, 1: state is not IDLE.

## Operation
- Three-state FSM: IDLE, ACCUM, DONE.
- IDLE: `in_ready=0`, `out_valid=0`.
  - `start=1` latches `len` and clears the accumulator, count and ovf.
  - If `len!=0`, next state is ACCUM.
  - If `len==0`, next state is DONE with `out_data=0`, `out_count=0`.
- ACCUM: `in_ready=1`.
  - Each cycle with `in_valid&in_ready`: `acc <= acc + zero_ext(in_data)` and `cnt <= cnt+1`.
  - On the accept where `cnt+1==len_q`, next state is DONE.
  - `in_data` is ignored when `in_valid=0`.
- DONE: `out_valid=1` and `in_ready=0`.
  - `out_data`, `out_count` and `out_ovf` hold stable until `out_valid&out_ready`; the next state is then IDLE.
- `start` is ignored in ACCUM and DONE.
- Overflow detection: `out_ovf` is set when the (ACC_W+1)-bit sum has its MSB set. It stays set until the next accepted `start`.
- Wrap behaviour (default): the accumulator keeps the sum modulo `2^ACC_W`.

## Timing
- Reset value of every register and output is 0: state IDLE, `in_ready`, `out_valid`, `out_data`, `out_count`, `out_ovf`, `busy`.
- Reset assertion mid-run aborts immediately. No result is produced, and the block sits in IDLE after reset release.
- `start` at edge k: ACCUM from k+1, so `in_ready=1` in cycle k+1.
- Last sample accepted at edge m: `out_valid=1` from cycle m+1.
- `len==0`: `out_valid=1` in the cycle after `start`.
- Output handshake at edge h: IDLE and `busy=0` from h+1.
  - The next `start` is accepted no earlier than edge h+1.
  - Minimum run-to-run gap is therefore 2 idle cycles of `in_ready`.
- `out_ready` asserted before DONE has no effect; `out_valid` does not depend combinationally on `out_ready`.
- `in_ready` and `out_valid` are decoded from registered state only.

## Configuration
- `EX_ACC_SAT_EN` defined: the accumulator saturates. Any sum above `2^ACC_W-1` loads `2^ACC_W-1` and later samples keep it there. `out_ovf` behaves identically in both modes.
- `EX_ACC_SAT_EN` undefined: the accumulator wraps modulo `2^ACC_W`.

## Test plan
- Basic run: `len=3`, samples 10, 20, 30 with no gaps -> `out_valid` one cycle after the third accept, `out_data=60`, `out_count=3`, `out_ovf=0`.
- Overflow, defaults: `len=15`, all samples 255 -> `out_data=753` and `out_ovf=1` without `EX_ACC_SAT_EN`; `out_data=1023` and `out_ovf=1` with it.
- Backpressure and gaps:
  - Random `in_valid` gaps in a `len=5` run of 1..5 -> `out_data=15`.
  - Hold `out_ready=0` for 10 cycles -> outputs stable, `in_ready=0`, and a `start` pulsed during DONE is ignored.
- Zero length: `len=0` -> `out_valid` in the next cycle with `out_data=0`, `out_count=0`, and no samples consumed.
- Reset mid-run: pull `clear_n` low after 2 of 4 samples -> all outputs 0 asynchronously. A new `len=2` run of 7, 8 then gives `out_data=15`.
- Back-to-back: `start` issued the cycle after the output handshake -> accepted; second run result is independent of the first and `out_ovf` is cleared.
